// File: rtl/adder_n_prefix_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with carry-in folded in as bit -1,
// prefix levels spread over STAGES registers, global-stall valid/ready handshake.
module adder_n_prefix_pipe #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  // Prefix vector is N+1 wide: index 0 is the carry-in, index i+1 is operand bit i.
  localparam int unsigned M      = N + 1;
  localparam int unsigned IW     = $clog2(M);
  localparam int unsigned LEVELS = $clog2(M);
  localparam int unsigned BASE   = LEVELS / STAGES;
  localparam int unsigned EXTRA  = LEVELS % STAGES;

  // First prefix level handled by stage s; leftover levels go to the earliest stages.
  function automatic int unsigned lvl_start(input int unsigned s);
    return s * BASE + ((s < EXTRA) ? s : EXTRA);
  endfunction

  function automatic logic [M-1:0] prefix_g(input logic [M-1:0] g_i, input logic [M-1:0] p_i,
                                            input int unsigned lo, input int unsigned hi);
    logic [M-1:0] g, p, g_n, p_n;
    int unsigned  d;
    g = g_i;
    p = p_i;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      if (l >= lo && l < hi) begin
        d   = 32'd1 << l;
        g_n = g;
        p_n = p;
        for (int unsigned i = 0; i < M; i++) begin
          if (i >= d) begin
            g_n[IW'(i)] = g[IW'(i)] | (p[IW'(i)] & g[IW'(i - d)]);
            p_n[IW'(i)] = p[IW'(i)] & p[IW'(i - d)];
          end
        end
        g = g_n;
        p = p_n;
      end
    end
    return g;
  endfunction

  function automatic logic [M-1:0] prefix_p(input logic [M-1:0] p_i,
                                            input int unsigned lo, input int unsigned hi);
    logic [M-1:0] p, p_n;
    int unsigned  d;
    p = p_i;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      if (l >= lo && l < hi) begin
        d   = 32'd1 << l;
        p_n = p;
        for (int unsigned i = 0; i < M; i++) begin
          if (i >= d) p_n[IW'(i)] = p[IW'(i)] & p[IW'(i - d)];
        end
        p = p_n;
      end
    end
    return p;
  endfunction

  logic         adv;
  logic [N-1:0] bb;
  logic         cin_eff;
  logic [M-1:0] g0, p0;
  logic         seen_q;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Subtract is A + ~B + 1; carry-in becomes the bit -1 generate with zero propagate.
  assign bb      = sub ? ~b : b;
  assign cin_eff = sub | c_in;
  assign g0      = {a & bb, cin_eff};
  assign p0      = {a ^ bb, 1'b0};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = lvl_start(s);
    localparam int unsigned HI = lvl_start(s + 1);

    logic         v_d;
    logic [M-1:0] g_d, p_d;
    logic [N-1:0] pb_d;
    logic         vld_q;
    logic [M-1:0] g_q;
    logic [N-1:0] pb_q;

    if (s == 0) begin : g_head
      assign v_d  = in_valid;
      assign g_d  = g0;
      assign p_d  = p0;
      assign pb_d = p0[M-1:1];
    end else begin : g_link
      assign v_d  = g_stage[s-1].vld_q;
      assign g_d  = g_stage[s-1].g_q;
      assign p_d  = g_stage[s-1].g_pr.p_q;
      assign pb_d = g_stage[s-1].pb_q;
    end

    // Data only loads on valid beats so the last result persists through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        g_q   <= '0;
        pb_q  <= '0;
      end else if (adv) begin
        vld_q <= v_d;
        if (v_d) begin
          g_q  <= prefix_g(g_d, p_d, LO, HI);
          pb_q <= pb_d;
        end
      end
    end

    // Group propagate is dead after the final stage, so only earlier stages keep it.
    if (s < STAGES - 1) begin : g_pr
      logic [M-1:0] p_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          p_q <= '0;
        else if (adv && v_d) p_q <= prefix_p(p_d, LO, HI);
      end
    end
  end

  // Masks the zero flag until the first real result has reached the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                seen_q <= 1'b0;
    else if (adv && g_stage[STAGES-1].v_d)     seen_q <= 1'b1;
  end

  logic [M-1:0] g_f;
  logic [N-1:0] pb_f;

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign g_f       = g_stage[STAGES-1].g_q;
  assign pb_f      = g_stage[STAGES-1].pb_q;

  // g_f[i] is the carry into bit i; g_f[N] is the carry out of bit N-1.
  assign sum   = pb_f ^ g_f[N-1:0];
  assign c_out = g_f[N];
  assign ovf   = g_f[N-1] ^ g_f[N];
  assign neg   = sum[N-1];
  assign zero  = seen_q & ~(|sum);

endmodule

// File: tb/tb_adder_n_prefix_pipe.sv
// Scoreboard bench for adder_n_prefix_pipe: five width/depth configurations share one
// stimulus stream; configuration 0 (N=32, STAGES=2) also gets cycle-exact directed checks.
module tb_adder_n_prefix_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, c_in, sub;
  logic [31:0] a, b;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic        end_chk  = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: {c_out, ovf, zero, neg, sum} from plain (w+1)-bit arithmetic.
  function automatic logic [63:0] model(input int unsigned w, input logic [31:0] av,
                                        input logic [31:0] bv, input logic ci, input logic sb);
    logic [31:0] mask, am, bm, s, t;
    logic [32:0] full, ft;
    logic        c, o, z, n, as, bs;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am   = av & mask;
    bm   = (sb ? ~bv : bv) & mask;
    full = {1'b0, am} + {1'b0, bm} + 33'(sb ? 1'b1 : ci);
    s    = full[31:0] & mask;
    ft   = full >> w;
    c    = ft[0];
    t    = s >> (w - 1);
    n    = t[0];
    t    = am >> (w - 1);
    as   = t[0];
    t    = bm >> (w - 1);
    bs   = t[0];
    z    = (s == 32'd0);
    o    = (as == bs) && (n != as);
    return {28'd0, c, o, z, n, s};
  endfunction

  for (genvar k = 0; k < 5; k++) begin : g_dut
    localparam int unsigned NW = (k == 2 || k == 4) ? 13 : 32;
    localparam int unsigned ST = (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 3 : 4;

    logic          ir, ov, co, of, zr, ng;
    logic [NW-1:0] sm;
    logic [63:0]   obs, hold;
    logic [63:0]   q[$];
    logic          hold_v = 1'b0;
    int unsigned   n_out  = 0;
    int unsigned   n_acc  = 0;

    adder_n_prefix_pipe #(.N(NW), .STAGES(ST)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (ir),
      .a        (a[NW-1:0]),
      .b        (b[NW-1:0]),
      .c_in     (c_in),
      .sub      (sub),
      .out_valid(ov),
      .out_ready(out_ready),
      .sum      (sm),
      .c_out    (co),
      .ovf      (of),
      .zero     (zr),
      .neg      (ng)
    );

    assign obs = {28'd0, co, of, zr, ng, 32'(sm)};

    // Pop on handshakes, check stall stability, push on acceptance (sampled mid-cycle).
    always @(negedge clk) begin
      if (!rst_n) begin
        n_acc  = n_acc - 32'(q.size());
        q.delete();
        hold_v = 1'b0;
      end else begin
        if (ov && hold_v) check($sformatf("cfg%0d stall_hold", k), obs, hold);
        hold_v = 1'b0;
        if (ov && out_ready) begin
          check($sformatf("cfg%0d queue_nonempty", k), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            check($sformatf("cfg%0d result", k), obs, q.pop_front());
            n_out++;
          end
        end else if (ov) begin
          hold   = obs;
          hold_v = 1'b1;
        end
        if (in_valid && ir) begin
          q.push_back(model(NW, a, b, c_in, sub));
          n_acc++;
        end
      end
    end

    always @(posedge end_chk) begin
      check($sformatf("cfg%0d drained", k), 64'(q.size()), 64'd0);
      check($sformatf("cfg%0d in_eq_out", k), 64'(n_out), 64'(n_acc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb);
    in_valid = v;
    a        = av;
    b        = bv;
    c_in     = ci;
    sub      = sb;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned acc, cyc, out0;

    // Reset
    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(g_dut[0].ov), 64'd0);
    check("reset outputs", g_dut[0].obs, 64'd0);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 64'(g_dut[0].ir), 64'd1);
    check("post-reset outputs", g_dut[0].obs, 64'd0);
    tick();

    // Signed overflow add, exact two-cycle latency
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("ovf latency_early", 64'(g_dut[0].ov), 64'd0);
    tick();
    check("ovf out_valid", 64'(g_dut[0].ov), 64'd1);
    check("ovf result", g_dut[0].obs, {28'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0000});
    tick();

    // Subtract with borrow, then equal operands
    drive(1'b1, 32'd5, 32'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'd7, 32'd7, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("sub5-7 valid", 64'(g_dut[0].ov), 64'd1);
    check("sub5-7 result", g_dut[0].obs, {28'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE});
    tick();
    check("sub7-7 result", g_dut[0].obs, {28'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000});
    tick();

    // Wrap-around and back-to-back add/sub at full rate
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    tick();
    check("wrap result", g_dut[0].obs, {28'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000});
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
    tick();
    check("b2b add result", g_dut[0].obs, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001});
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check("b2b sub valid", 64'(g_dut[0].ov), 64'd1);
    check("b2b sub result", g_dut[0].obs, {28'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE});
    tick();
    check("idle out_valid", 64'(g_dut[0].ov), 64'd0);
    check("idle hold", g_dut[0].obs, {28'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE});

    // Backpressure: pipeline fills with exactly STAGES beats, then resumes at full rate
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
      #1;
      if (g_dut[0].ir) acc++;
      tick();
    end
    check("bp accepted", 64'(acc), 64'd2);
    check("bp in_ready", 64'(g_dut[0].ir), 64'd0);
    check("bp out_valid", 64'(g_dut[0].ov), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
      #1;
      check("bp resume in_ready", 64'(g_dut[0].ir), 64'd1);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (6) tick();

    // Reset with two beats in flight
    drive(1'b1, 32'd100, 32'd23, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd9, 32'd4, 1'b0, 1'b1);
    tick();
    check("midrst pre out_valid", 64'(g_dut[0].ov), 64'd1);
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check("midrst out_valid", 64'(g_dut[0].ov), 64'd0);
    check("midrst outputs", g_dut[0].obs, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("midrst no_stale", 64'(g_dut[0].ov), 64'd0);
      tick();
    end

    // Random streaming with 50% out_ready
    out0 = g_dut[0].n_out;
    acc  = 0;
    cyc  = 0;
    while (acc < 100 && cyc < 2000) begin
      out_ready = 1'($urandom);
      drive(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
      #1;
      if (g_dut[0].ir) acc++;
      tick();
      cyc++;
    end
    check("rand accepted", 64'(acc), 64'd100);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (10) tick();
    check("rand outputs", 64'(g_dut[0].n_out - out0), 64'd100);

    #2;
    end_chk = 1'b1;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
